// File: rtl/reg_share_arbiter.sv
// Shared-register write controller: arbitrates NREQ requesters for bounded write bursts into one WIDTH-bit register.
// Optional feature: define REG_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module reg_share_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NREQ-1:0]          req_in,
  input  logic [NREQ*WIDTH-1:0]    d_in,
  output logic [NREQ-1:0]          gnt_out,
  output logic [WIDTH-1:0]         q_out,
  output logic [$clog2(NREQ)-1:0]  owner_out,
  output logic                     valid_out
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    win;
  logic             found;
  logic [3:0]       cnt_inc;
  int               idx;
`ifndef REG_SHARE_FIXED_PRIO_EN
  logic [IW-1:0]    rr_q, rr_d;
`endif

  // Winner search: first set request scanning upward from the start index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef REG_SHARE_FIXED_PRIO_EN
      idx = i;
`else
      idx = (int'(rr_q) + i) % NREQ;
`endif
      if (!found && req_in[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    owner_d = owner_q;
    valid_d = valid_q;
    cnt_inc = cnt_q + 4'd1;
`ifndef REG_SHARE_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = win;
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (req_in[owner_q]) begin
          q_d     = d_in[int'(owner_q)*WIDTH +: WIDTH];
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == 4'(MAX_BURST)) state_d = S_RELEASE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
`ifndef REG_SHARE_FIXED_PRIO_EN
        rr_d = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
`ifndef REG_SHARE_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
`ifndef REG_SHARE_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Grant is decoded from registered state only, so it drops during RELEASE/IDLE.
  always_comb begin
    gnt_out = '0;
    if (state_q == S_WRITE) gnt_out[owner_q] = 1'b1;
  end

  assign q_out     = q_q;
  assign owner_out = owner_q;
  assign valid_out = valid_q;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: vector table plus hand sequences, scoreboard-compared per clock.
module tb_reg_share_arbiter;
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [3:0]  req_in = '0;
  logic [31:0] d_in = '0;
  logic [3:0]  gnt_out;
  logic [7:0]  q_out;
  logic [1:0]  owner_out;
  logic        valid_out;

`ifdef REG_SHARE_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  reg_share_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .res(res), .req_in(req_in), .d_in(d_in),
    .gnt_out(gnt_out), .q_out(q_out), .owner_out(owner_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] q;
    logic [1:0] own;
    logic       vld;
  } exp_t;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] d;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stepno = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, stepno, act, want);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("gnt_out",   32'(gnt_out),   32'(e.gnt));
    chk("q_out",     32'(q_out),     32'(e.q));
    chk("owner_out", 32'(owner_out), 32'(e.own));
    chk("valid_out", 32'(valid_out), 32'(e.vld));
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1; req_in = '0; d_in = '0;
    #2;
    chk_all('{gnt: 4'b0000, q: 8'h00, own: 2'd0, vld: 1'b0});
    @(negedge clk);
    res = 1'b0;
  endtask

  task automatic step(input logic [3:0] req, input logic [31:0] d, input exp_t e);
    exp_t got;
    @(negedge clk);
    req_in = req; d_in = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", stepno);
    end else begin
      got = sb.pop_front();
      chk_all(got);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [7:0] q, input logic [1:0] o, input logic v);
    exp_t e;
    e.gnt = g; e.q = q; e.own = o; e.vld = v;
    return e;
  endfunction

  task automatic add(input bit r, input logic [3:0] req, input logic [31:0] d, input exp_t e);
    vec_t v;
    v.rst = r; v.req = req; v.d = d; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] sl;
    int n, ph, o;

    // Test 1: single requester 0, burst of 4, 2-cycle gap, re-grant.
    add(1, 4'b0001, 32'h0000_00A5, mk(4'b0001, 8'h00, 2'd0, 1'b0));
    for (int c = 2; c <= 4; c++) add(0, 4'b0001, 32'h0000_00A5, mk(4'b0001, 8'hA5, 2'd0, 1'b1));
    add(0, 4'b0001, 32'h0000_00A5, mk(4'b0000, 8'hA5, 2'd0, 1'b1));
    add(0, 4'b0001, 32'h0000_00A5, mk(4'b0000, 8'hA5, 2'd0, 1'b1));
    add(0, 4'b0001, 32'h0000_00A5, mk(4'b0001, 8'hA5, 2'd0, 1'b1));
    add(0, 4'b0001, 32'h0000_00A5, mk(4'b0001, 8'hA5, 2'd0, 1'b1));

    // Test 2: all requesting; grant schedule is 4 WRITE cycles then 2 idle cycles per owner.
    for (int c = 1; c <= 30; c++) begin
      n  = (c - 1) / 6;
      ph = (c - 1) % 6;
      o  = FIXED ? 0 : n % 4;
      if (ph >= 1)     sl = 8'(8'h11 * (o + 1));
      else if (n > 0)  sl = 8'(8'h11 * ((FIXED ? 0 : (n - 1) % 4) + 1));
      else             sl = 8'h00;
      add(c == 1, 4'b1111, 32'h4433_2211,
          mk(ph < 4 ? 4'(1 << o) : 4'b0000, sl, 2'(o), c >= 2));
    end

    // Test 6: other requesters' data toggles while requester 3 owns the register.
    for (int c = 1; c <= 6; c++) begin
      add(c == 1, 4'b1000, {8'h77, 24'($urandom)},
          mk(c <= 4 ? 4'b1000 : 4'b0000, c >= 2 ? 8'h77 : 8'h00, 2'd3, c >= 2));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req, tbl[i].d, tbl[i].e);
    end

    // Test 3: owner 2 drops request after two writes; pointer moves to 3 ahead of pending 1.
    do_reset();
    step(4'b0100, 32'h003C_0000, mk(4'b0100, 8'h00, 2'd2, 1'b0));
    step(4'b0100, 32'h003C_0000, mk(4'b0100, 8'h3C, 2'd2, 1'b1));
    step(4'b0100, 32'h00C3_0000, mk(4'b0100, 8'hC3, 2'd2, 1'b1));
    step(4'b1010, 32'h9900_1100, mk(4'b0000, 8'hC3, 2'd2, 1'b1));
    step(4'b1010, 32'h9900_1100, mk(4'b0000, 8'hC3, 2'd2, 1'b1));
    if (FIXED) begin
      step(4'b1010, 32'h9900_1100, mk(4'b0010, 8'hC3, 2'd1, 1'b1));
      step(4'b1010, 32'h9900_1100, mk(4'b0010, 8'h11, 2'd1, 1'b1));
    end else begin
      step(4'b1010, 32'h9900_1100, mk(4'b1000, 8'hC3, 2'd3, 1'b1));
      step(4'b1010, 32'h9900_1100, mk(4'b1000, 8'h99, 2'd3, 1'b1));
    end

    // Test 4: asynchronous reset in the middle of owner 1's burst.
    do_reset();
    step(4'b0001, 32'h0000_55AA, mk(4'b0001, 8'h00, 2'd0, 1'b0));
    for (int c = 2; c <= 4; c++) step(4'b0001, 32'h0000_55AA, mk(4'b0001, 8'hAA, 2'd0, 1'b1));
    step(4'b0000, 32'h0000_55AA, mk(4'b0000, 8'hAA, 2'd0, 1'b1));
    step(4'b0000, 32'h0000_55AA, mk(4'b0000, 8'hAA, 2'd0, 1'b1));
    step(4'b0010, 32'h0000_55AA, mk(4'b0010, 8'hAA, 2'd1, 1'b1));
    step(4'b0010, 32'h0000_55AA, mk(4'b0010, 8'h55, 2'd1, 1'b1));
    @(negedge clk);
    res = 1'b1; req_in = '0;
    #1;
    stepno++;
    chk_all(mk(4'b0000, 8'h00, 2'd0, 1'b0));
    #2;
    res = 1'b0;
    step(4'b0011, 32'h0000_55AA, mk(4'b0001, 8'h00, 2'd0, 1'b0));
    step(4'b0011, 32'h0000_55AA, mk(4'b0001, 8'hAA, 2'd0, 1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
